// File: rtl/bcd_pkg.sv
// Shared definitions for the shared binary-to-BCD conversion scheduler.
// Contents: FSM state type, BCD nibble width, double-dabble adjust
// constants, and a helper that computes the minimum number of BCD digits
// needed to represent an N-bit unsigned value.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam int BCD_W      = 4;
  localparam int ADJ_THRESH = 5;
  localparam int ADJ_ADD    = 3;

  // Smallest digit count d with 10^d > 2^n - 1.
  function automatic int min_digits(input int n);
    longint maxv;
    longint lim;
    int     d;
    maxv = (64'sd1 <<< n) - 64'sd1;
    lim  = 64'sd10;
    d    = 1;
    for (int i = 0; i < 19; i++) begin
      if (lim <= maxv) begin
        d   = d + 1;
        lim = lim * 64'sd10;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_conv_scheduler_if.sv
// Bundle between the two display requesters and the conversion scheduler.
// master: requester side (drives req/bin0/bin1, observes results)
// slave : scheduler side (observes requests, drives gnt_id/busy/done/tens/units)
interface bcd_conv_scheduler_if #(
  parameter int N = 6
);

  logic [1:0]                 req;
  logic [N-1:0]               bin0;
  logic [N-1:0]               bin1;
  logic                       gnt_id;
  logic                       busy;
  logic [1:0]                 done;
  logic [bcd_pkg::BCD_W-1:0]  tens;
  logic [bcd_pkg::BCD_W-1:0]  units;

  modport master (
    output req, bin0, bin1,
    input  gnt_id, busy, done, tens, units
  );

  modport slave (
    input  req, bin0, bin1,
    output gnt_id, busy, done, tens, units
  );

endinterface

// File: rtl/bcd_conv_scheduler_dd_step.sv
// One double-dabble iteration, purely combinational.
// Ports:
//   cur : current {bcd digits, remaining binary bits}
//   nxt : after add-3 on every BCD nibble >= 5 and a left shift by one
module dd_step
  import bcd_pkg::*;
#(
  parameter int N      = 6,
  parameter int DIGITS = 2
) (
  input  logic [DIGITS*BCD_W+N-1:0] cur,
  output logic [DIGITS*BCD_W+N-1:0] nxt
);

  localparam int W = DIGITS*BCD_W + N;

  logic [W-1:0] adj_s;

  // Per-nibble add-3 correction, then shift the whole vector left by one.
  always_comb begin
    adj_s = cur;
    for (int d = 0; d < DIGITS; d++) begin
      if (cur[N + d*BCD_W +: BCD_W] >= BCD_W'(ADJ_THRESH)) begin
        adj_s[N + d*BCD_W +: BCD_W] = cur[N + d*BCD_W +: BCD_W] + BCD_W'(ADJ_ADD);
      end else begin
        adj_s[N + d*BCD_W +: BCD_W] = cur[N + d*BCD_W +: BCD_W];
      end
    end
    nxt = {adj_s[W-2:0], 1'b0};
  end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Shared binary-to-BCD conversion engine for two requesters.
// Round-robin arbitration in IDLE, N double-dabble shift cycles, then a
// one-cycle DONE state that pulses done[gnt_id]. All outputs registered.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd_conv_scheduler_if (req/bin0/bin1 in,
//           gnt_id/busy/done/tens/units out)
module bcd_conv_scheduler
  import bcd_pkg::*;
#(
  parameter int N      = 6,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_conv_scheduler_if.slave   bus
);

  localparam int CW = $clog2(N + 1);
  localparam int BW = DIGITS * BCD_W;

  // Reject digit counts too small for the full binary range.
  generate
    if (DIGITS < min_digits(N)) begin : g_bad_digits
      $error("bcd_conv_scheduler: DIGITS too small for N-bit input");
    end
  endgenerate

  conv_state_t      state_r;
  logic             gnt_r;
  logic             last_r;
  logic             busy_r;
  logic [1:0]       done_r;
  logic [BCD_W-1:0] tens_r;
  logic [BCD_W-1:0] units_r;
  logic [CW-1:0]    cnt_r;
  logic [N-1:0]     shift_r;
  logic [BW-1:0]    bcd_r;

  logic             winner_s;
  logic [BW+N-1:0]  step_in_s;
  logic [BW+N-1:0]  step_out_s;

  // Round-robin pick: with both requesting, serve the one not served last.
  always_comb begin
    if (bus.req == 2'b11) begin
      winner_s = ~last_r;
    end else if (bus.req[1]) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  assign step_in_s = {bcd_r, shift_r};

  dd_step #(
    .N      (N),
    .DIGITS (DIGITS)
  ) u_dd_step (
    .cur (step_in_s),
    .nxt (step_out_s)
  );

  // Scheduler FSM: grant, iterate the conversion, publish the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      gnt_r   <= 1'b0;
      last_r  <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 2'b00;
      tens_r  <= {BCD_W{1'b0}};
      units_r <= {BCD_W{1'b0}};
      cnt_r   <= {CW{1'b0}};
      shift_r <= {N{1'b0}};
      bcd_r   <= {BW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req != 2'b00) begin
            gnt_r   <= winner_s;
            shift_r <= winner_s ? bus.bin1 : bus.bin0;
            bcd_r   <= {BW{1'b0}};
            cnt_r   <= CW'(N);
            busy_r  <= 1'b1;
            state_r <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          {bcd_r, shift_r} <= step_out_s;
          cnt_r            <= cnt_r - CW'(1);
          // Digits land on the same edge as the final shift.
          if (cnt_r == CW'(1)) begin
            tens_r  <= step_out_s[N + BCD_W +: BCD_W];
            units_r <= step_out_s[N +: BCD_W];
            done_r  <= gnt_r ? 2'b10 : 2'b01;
            state_r <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          done_r  <= 2'b00;
          busy_r  <= 1'b0;
          last_r  <= gnt_r;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 2'b00;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt_id = gnt_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.tens   = tens_r;
  assign bus.units  = units_r;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Scoreboard bench for bcd_conv_scheduler: stimulus pushes expected
// {requester, tens, units} computed with plain division, a monitor pops
// and compares on every done pulse.
module tb_bcd_conv_scheduler;

  localparam int N = 6;

  typedef struct {
    int id;
    int t;
    int u;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  int   last_m;
  logic [1:0] prev_done;
  exp_t exp_q[$];

  bcd_conv_scheduler_if #(.N(N)) bif ();

  bcd_conv_scheduler #(.N(N), .DIGITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bif.done != 2'b00) begin
      check("done_one_cycle", int'(prev_done), 0);
      if (exp_q.size() == 0) begin
        check("spurious_done", int'(bif.done), 0);
      end else begin
        e = exp_q.pop_front();
        check("gnt_id", int'(bif.gnt_id), e.id);
        check("done_bit", int'(bif.done), (e.id == 1) ? 2 : 1);
        check("tens", int'(bif.tens), e.t);
        check("units", int'(bif.units), e.u);
      end
    end
    prev_done = rst_n ? bif.done : 2'b00;
  end

  task automatic model_push(input int id, input int v);
    exp_t e;
    e.id = id;
    e.t  = v / 10;
    e.u  = v % 10;
    exp_q.push_back(e);
    last_m = id;
  endtask

  task automatic check_reset_outputs();
    check("rst_tens", int'(bif.tens), 0);
    check("rst_units", int'(bif.units), 0);
    check("rst_busy", int'(bif.busy), 0);
    check("rst_done", int'(bif.done), 0);
    check("rst_gnt", int'(bif.gnt_id), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bif.req = 2'b00;
    last_m = 1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait for every pending requester to be served; drop req on its done,
  // and scramble the granted requester's input mid-conversion.
  task automatic wait_served(input logic [1:0] pend, input int t0);
    logic [1:0] m;
    int n;
    int bcnt;
    int lastd;
    bit first;
    m = pend;
    n = 0;
    bcnt = 0;
    lastd = 0;
    first = 1'b1;
    while (m != 2'b00 && n < 60) begin
      @(negedge clk);
      n++;
      if (bif.busy) bcnt++; else bcnt = 0;
      if (bcnt == 1 && first) check("busy_rise", cyc - t0, 1);
      if (bcnt == 3) begin
        if (bif.gnt_id) bif.bin1 = bif.bin1 ^ 6'($urandom_range(1, 63));
        else            bif.bin0 = bif.bin0 ^ 6'($urandom_range(1, 63));
      end
      if (bif.done != 2'b00) begin
        if (first) check("latency", cyc - t0, N + 1);
        else       check("rr_gap", cyc - lastd, N + 2);
        first = 1'b0;
        lastd = cyc;
        m = m & ~bif.done;
        bif.req = bif.req & ~bif.done;
      end
    end
    if (m != 2'b00) begin
      check("served_timeout", int'(m), 0);
      bif.req = 2'b00;
    end
  endtask

  task automatic issue(input logic [1:0] pat, input int v0, input int v1);
    int t0;
    @(negedge clk);
    bif.bin0 = 6'(v0);
    bif.bin1 = 6'(v1);
    if (pat == 2'b11) begin
      if (last_m == 1) begin
        model_push(0, v0);
        model_push(1, v1);
      end else begin
        model_push(1, v1);
        model_push(0, v0);
      end
    end else if (pat == 2'b10) begin
      model_push(1, v1);
    end else begin
      model_push(0, v0);
    end
    bif.req = pat;
    t0 = cyc;
    wait_served(pat, t0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    total = 0;
    bad = 0;
    cyc = 0;
    last_m = 1;
    prev_done = 2'b00;
    rst_n = 1'b0;
    bif.req = 2'b00;
    bif.bin0 = 6'd0;
    bif.bin1 = 6'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    // Simultaneous requests right after reset: requester 0 first.
    issue(2'b11, 63, 10);

    // Single requester after a fresh reset.
    do_reset();
    issue(2'b01, 45, 0);

    // Both requesting repeatedly: strict alternation.
    for (int i = 0; i < 3; i++) issue(2'b11, 7, 58);

    // Boundary and input-ignored-after-grant cases.
    issue(2'b01, 0, 0);
    issue(2'b01, 9, 0);
    issue(2'b10, 0, 22);

    // Reset during SHIFT discards the conversion; req0 held is re-served.
    @(negedge clk);
    bif.bin0 = 6'd38;
    bif.req = 2'b01;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    last_m = 1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    model_push(0, 38);
    t0 = cyc;
    wait_served(2'b01, t0);

    // Idle stability after a 4/2 result.
    issue(2'b01, 42, 0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i % 5 == 0) begin
        check("idle_tens", int'(bif.tens), 4);
        check("idle_units", int'(bif.units), 2);
        check("idle_busy", int'(bif.busy), 0);
        check("idle_done", int'(bif.done), 0);
      end
    end

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(1, 3)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
